// File: rtl/trig_hit_decoder.sv
// Trigger-word decoder: locks a flywheel BCID phase to the alternating 0xFFFF/0x0000 orbit marker.
// One register stage from encTrigHits to all outputs; free-running stream, no backpressure.
module trig_hit_decoder #(
   parameter int ORBIT_LEN     = 3564,
   parameter int LOCK_THRESH   = 4,
   parameter int UNLOCK_THRESH = 3,
   parameter int ERR_W         = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [15:0]      encTrigHits,
   input  logic [11:0]      emptySlotBCID,
   input  logic             clrErr,
   output logic [15:0]      trigHits,
   output logic [11:0]      bcid,
   output logic             hitsValid,
   output logic             markerSeen,
   output logic             locked,
   output logic [ERR_W-1:0] errCnt
);

   localparam int CW = $clog2(LOCK_THRESH + 1);
   localparam int MW = $clog2(UNLOCK_THRESH + 1);
   localparam logic [11:0]      PH_LAST  = 12'(ORBIT_LEN - 1);
   localparam logic [12:0]      ORBIT_N  = 13'(ORBIT_LEN);
   localparam logic [CW-1:0]    LOCK_N   = CW'(LOCK_THRESH);
   localparam logic [CW-1:0]    C_ONE    = CW'(1);
   localparam logic [MW-1:0]    UNLOCK_N = MW'(UNLOCK_THRESH);
   localparam logic [MW-1:0]    M_ONE    = MW'(1);
   localparam logic [ERR_W-1:0] E_ONE    = ERR_W'(1);

   typedef enum logic [1:0] {SEARCH, CONFIRM, LOCKED} state_t;

   state_t           state_q, state_d;
   logic [11:0]      phase_q, phase_d;
   logic [CW-1:0]    confirm_cnt_q, confirm_cnt_d;
   logic [MW-1:0]    miss_cnt_q, miss_cnt_d;
   logic             exp_pol_q, exp_pol_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
   logic [15:0]      trig_hits_q, trig_hits_d;
   logic [11:0]      bcid_q, bcid_d;
   logic             hits_valid_q, hits_valid_d;
   logic             marker_seen_q, marker_seen_d;
   logic             locked_q, locked_d;

   logic             marker_slot;
   logic             pol_match;
   logic             arm;
   logic             err_inc;
   logic [CW-1:0]    confirm_inc;
   logic [MW-1:0]    miss_inc;
   logic [12:0]      bcid_sum;

   assign marker_slot = (phase_q == 12'd0);
   assign pol_match   = (encTrigHits == {16{exp_pol_q}});
   assign arm         = (encTrigHits == 16'hFFFF);
   assign confirm_inc = confirm_cnt_q + C_ONE;
   assign miss_inc    = miss_cnt_q + M_ONE;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= SEARCH;
         phase_q       <= 12'd0;
         confirm_cnt_q <= '0;
         miss_cnt_q    <= '0;
         exp_pol_q     <= 1'b0;
         err_cnt_q     <= '0;
         trig_hits_q   <= 16'd0;
         bcid_q        <= 12'd0;
         hits_valid_q  <= 1'b0;
         marker_seen_q <= 1'b0;
         locked_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         phase_q       <= phase_d;
         confirm_cnt_q <= confirm_cnt_d;
         miss_cnt_q    <= miss_cnt_d;
         exp_pol_q     <= exp_pol_d;
         err_cnt_q     <= err_cnt_d;
         trig_hits_q   <= trig_hits_d;
         bcid_q        <= bcid_d;
         hits_valid_q  <= hits_valid_d;
         marker_seen_q <= marker_seen_d;
         locked_q      <= locked_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      phase_d       = (phase_q == PH_LAST) ? 12'd0 : phase_q + 12'd1;
      confirm_cnt_d = confirm_cnt_q;
      miss_cnt_d    = miss_cnt_q;
      exp_pol_d     = exp_pol_q;
      err_inc       = 1'b0;
      case (state_q)
         SEARCH: begin
            // The arming word itself is the phase-0 slot of the candidate orbit.
            if (arm) begin
               phase_d       = 12'd1;
               exp_pol_d     = 1'b0;
               confirm_cnt_d = C_ONE;
               state_d       = CONFIRM;
            end
         end
         CONFIRM: begin
            if (marker_slot) begin
               if (pol_match) begin
                  confirm_cnt_d = confirm_inc;
                  exp_pol_d     = ~exp_pol_q;
                  if (confirm_inc == LOCK_N) begin
                     state_d    = LOCKED;
                     miss_cnt_d = '0;
                  end
               end else begin
                  state_d       = SEARCH;
                  confirm_cnt_d = '0;
                  miss_cnt_d    = '0;
               end
            end
         end
         LOCKED: begin
            if (marker_slot) begin
               exp_pol_d = ~exp_pol_q;
               if (pol_match) begin
                  miss_cnt_d = '0;
               end else begin
                  miss_cnt_d = miss_inc;
                  err_inc    = 1'b1;
                  if (miss_inc == UNLOCK_N) begin
                     state_d       = SEARCH;
                     confirm_cnt_d = '0;
                     miss_cnt_d    = '0;
                  end
               end
            end
         end
         default: state_d = SEARCH;
      endcase

      err_cnt_d = err_cnt_q;
      if (clrErr)
         err_cnt_d = '0;
      else if (err_inc && (err_cnt_q != '1))
         err_cnt_d = err_cnt_q + E_ONE;
   end

   always_comb begin
      trig_hits_d   = encTrigHits;
      bcid_d        = 12'd0;
      hits_valid_d  = 1'b0;
      marker_seen_d = 1'b0;
      locked_d      = (state_d == LOCKED);
      bcid_sum      = {1'b0, emptySlotBCID} + {1'b0, phase_q};
      if (state_q == LOCKED) begin
         bcid_d = (bcid_sum >= ORBIT_N) ? 12'(bcid_sum - ORBIT_N) : bcid_sum[11:0];
         if (marker_slot) begin
            trig_hits_d   = 16'd0;
            marker_seen_d = 1'b1;
         end else begin
            hits_valid_d  = 1'b1;
         end
      end
   end

   assign trigHits   = trig_hits_q;
   assign bcid       = bcid_q;
   assign hitsValid  = hits_valid_q;
   assign markerSeen = marker_seen_q;
   assign locked     = locked_q;
   assign errCnt     = err_cnt_q;

endmodule

// File: tb/tb_trig_hit_decoder.sv
// Bench for trig_hit_decoder: encoder model drives markers and random hits; a phase-anchor
// reference model predicts every output cycle by cycle, with directed scenario checks on top.
module tb_trig_hit_decoder;

   localparam int L      = 16;
   localparam int LOCK_T = 4;
   localparam int UNL_T  = 3;
   localparam int EW     = 2;
   localparam int ESB    = 5;
   localparam int ERRMAX = (1 << EW) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic [15:0]   encTrigHits;
   logic [11:0]   emptySlotBCID;
   logic          clrErr;
   logic [15:0]   trigHits;
   logic [11:0]   bcid;
   logic          hitsValid;
   logic          markerSeen;
   logic          locked;
   logic [EW-1:0] errCnt;

   always #5 clk = ~clk;

   trig_hit_decoder #(
      .ORBIT_LEN(L), .LOCK_THRESH(LOCK_T), .UNLOCK_THRESH(UNL_T), .ERR_W(EW)
   ) dut (
      .clk(clk), .reset(reset), .encTrigHits(encTrigHits), .emptySlotBCID(emptySlotBCID),
      .clrErr(clrErr), .trigHits(trigHits), .bcid(bcid), .hitsValid(hitsValid),
      .markerSeen(markerSeen), .locked(locked), .errCnt(errCnt)
   );

   int tests = 0;
   int fails = 0;

   // encoder model state
   int cyc    = 0;
   int mk_off = 0;
   bit enc_pol = 1'b1;
   bit corrupt_next = 1'b0;
   bit clr_on_marker = 1'b0;
   bit spurious_now = 1'b0;

   // reference model state: mode 0=searching, 1=confirming, 2=locked
   int mode = 0;
   int anchor = 0;
   int good = 0;
   int miss = 0;
   int err = 0;
   bit pol = 1'b0;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic int enc_pos();
      return ((cyc - mk_off) % L + L) % L;
   endfunction

   task automatic gen(output logic [15:0] w, output logic c);
      c = 1'b0;
      if (spurious_now) begin
         w = 16'hFFFF;
         spurious_now = 1'b0;
      end else if (enc_pos() == 0) begin
         w = enc_pol ? 16'hFFFF : 16'h0000;
         if (corrupt_next) begin
            w = 16'h1234;
            corrupt_next = 1'b0;
         end
         if (clr_on_marker) begin
            c = 1'b1;
            clr_on_marker = 1'b0;
         end
         enc_pol = !enc_pol;
      end else begin
         w = 16'($urandom_range(32'hFFFE, 1));
      end
   endtask

   task automatic model_reset();
      mode = 0; good = 0; miss = 0; err = 0; pol = 1'b0;
   endtask

   task automatic tick();
      logic [15:0] w;
      logic        c;
      int          ph;
      logic [15:0] e_trig;
      logic        e_vld, e_seen;
      int          e_bcid;
      logic [15:0] pat;
      gen(w, c);
      encTrigHits = w;
      clrErr = c;
      @(posedge clk);
      #1;
      ph = ((cyc - anchor) % L + L) % L;
      e_trig = w; e_vld = 1'b0; e_seen = 1'b0; e_bcid = 0;
      if (mode == 2) begin
         e_bcid = (ESB + ph) % L;
         if (ph == 0) begin
            e_trig = 16'h0000;
            e_seen = 1'b1;
         end else begin
            e_vld = 1'b1;
         end
      end
      pat = pol ? 16'hFFFF : 16'h0000;
      if (mode == 0) begin
         if (w == 16'hFFFF) begin
            anchor = cyc; pol = 1'b0; good = 1; mode = 1;
         end
      end else if (mode == 1) begin
         if (ph == 0) begin
            if (w == pat) begin
               good++;
               pol = !pol;
               if (good >= LOCK_T) begin mode = 2; miss = 0; end
            end else begin
               mode = 0; good = 0; miss = 0;
            end
         end
      end else if (ph == 0) begin
         pol = !pol;
         if (w == pat) miss = 0;
         else begin
            miss++;
            if (err < ERRMAX) err++;
            if (miss >= UNL_T) begin mode = 0; miss = 0; good = 0; end
         end
      end
      if (c) err = 0;
      check("trigHits", trigHits, e_trig);
      check("hitsValid", 16'(hitsValid), 16'(e_vld));
      check("markerSeen", 16'(markerSeen), 16'(e_seen));
      check("bcid", 16'(bcid), 16'(e_bcid));
      check("locked", 16'(locked), (mode == 2) ? 16'd1 : 16'd0);
      check("errCnt", 16'(errCnt), 16'(err));
      cyc++;
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic run_to_marker();
      for (int i = 0; i < L; i++) begin
         if (enc_pos() == 0) break;
         tick();
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_trigHits"}, trigHits, 16'd0);
      check({tag, "_bcid"}, 16'(bcid), 16'd0);
      check({tag, "_hitsValid"}, 16'(hitsValid), 16'd0);
      check({tag, "_markerSeen"}, 16'(markerSeen), 16'd0);
      check({tag, "_locked"}, 16'(locked), 16'd0);
      check({tag, "_errCnt"}, 16'(errCnt), 16'd0);
   endtask

   // Asserts reset mid-cycle, holds it two edges while the encoder keeps running.
   task automatic apply_reset(input string tag);
      logic [15:0] w;
      logic        c;
      #3 reset = 1'b0;
      #1 check_all_zero(tag);
      model_reset();
      for (int i = 0; i < 2; i++) begin
         gen(w, c);
         encTrigHits = w;
         clrErr = c;
         @(posedge clk);
         #1 check_all_zero({tag, "_hold"});
         cyc++;
      end
      reset = 1'b1;
   endtask

   int pulses;

   initial begin
      reset = 1'b1;
      encTrigHits = 16'd0;
      clrErr = 1'b0;
      emptySlotBCID = 12'(ESB);
      #2 reset = 1'b0;
      #1 check_all_zero("reset");
      model_reset();
      @(posedge clk);
      #1 reset = 1'b1;

      // acquisition: markers at cycles 0,16,32,48 -> locked after the 48th edge
      tick_n(48);
      check("t1_prelock", 16'(locked), 16'd0);
      tick();
      check("t1_lock", 16'(locked), 16'd1);
      pulses = 0;
      for (int i = 0; i < 64; i++) begin
         tick();
         if (markerSeen === 1'b1 && bcid === 12'(ESB)) pulses++;
      end
      check("t1_pulses", 16'(pulses), 16'd4);
      check("t1_err", 16'(errCnt), 16'd0);

      // single corrupted 0x0000 marker, then miss counter must clear on a good marker
      for (int k = 0; k < 3; k++) begin
         run_to_marker();
         if (!enc_pol) break;
         tick();
      end
      corrupt_next = 1'b1;
      tick();
      check("t3_err1", 16'(errCnt), 16'd1);
      check("t3_locked", 16'(locked), 16'd1);
      check("t3_seen", 16'(markerSeen), 16'd1);
      run_to_marker(); tick();
      run_to_marker(); corrupt_next = 1'b1; tick();
      run_to_marker(); corrupt_next = 1'b1; tick();
      check("t3_miss_cleared", 16'(locked), 16'd1);
      check("t3_err3", 16'(errCnt), 16'd3);

      // saturation at ERR_W=2, then clear on a mismatch cycle
      run_to_marker(); tick();
      run_to_marker(); corrupt_next = 1'b1; tick();
      check("t5_sat", 16'(errCnt), 16'd3);
      run_to_marker(); tick();
      run_to_marker(); corrupt_next = 1'b1; clr_on_marker = 1'b1; tick();
      check("t5_clr", 16'(errCnt), 16'd0);
      check("t5_locked", 16'(locked), 16'd1);

      // marker shifted by 3 cycles: three misses unlock, then relock at the new phase
      run_to_marker(); tick();
      tick_n(3);
      mk_off += 3;
      tick_n(29);
      check("t4_still_locked", 16'(locked), 16'd1);
      check("t4_err2", 16'(errCnt), 16'd2);
      tick_n(16);
      check("t4_unlocked", 16'(locked), 16'd0);
      check("t4_err3", 16'(errCnt), 16'd3);
      tick_n(5 * L);
      check("t4_relock", 16'(locked), 16'd1);

      // reset mid-orbit while locked, then a fresh four-marker acquisition
      tick_n(5);
      apply_reset("t6_rst");
      tick_n(48);
      check("t6_not_yet", 16'(locked), 16'd0);
      tick_n(48);
      check("t6_relock", 16'(locked), 16'd1);

      // spurious 0xFFFF in search, 7 cycles ahead of the true marker
      for (int k = 0; k < 3; k++) begin
         run_to_marker();
         if (enc_pol) begin tick(); break; end
         tick();
      end
      apply_reset("t2_rst");
      for (int i = 0; i < 2 * L; i++) begin
         if (enc_pos() == L - 7 && enc_pol) break;
         tick();
      end
      spurious_now = 1'b1;
      tick();
      tick_n(L);
      check("t2_no_false_lock", 16'(locked), 16'd0);
      tick_n(5 * L);
      check("t2_relock", 16'(locked), 16'd1);
      tick_n(2 * L);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/trig_hit_decoder.md
Name: trig_hit_decoder

Overview:
- Receive-side counterpart of the ETROC2 trigger-hit encoder.
- Accepts the 16-bit encoded trigger word stream. Locates the once-per-orbit empty-slot marker, which alternates between 0xFFFF and 0x0000 on successive orbits, and locks a flywheel phase counter to it.
- Emits decoded trigger hits with a recovered BCID.
- Used in the back-end/emulator data path and as the checker for the front-end trigger path.

Parameters:
- ORBIT_LEN, 3564: BCID slots per orbit; marker period in clk cycles.
- LOCK_THRESH, 4: consecutive correct markers, including the arming one, required to declare lock; must be at least 2.
- UNLOCK_THRESH, 3: consecutive missed or wrong markers while locked that force loss of lock.
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  input  1  40 MHz BX clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- encTrigHits  input  16  encoded trigger word, one per clk.
- emptySlotBCID  input  12  BCID value the transmitter uses as the empty slot; static.
- clrErr  input  1  synchronous clear of errCnt.
- trigHits  output  16  decoded hits, registered.
- bcid  output  12  recovered BCID aligned with trigHits.
- hitsValid  output  1  trigHits is a real hit word.
- markerSeen  output  1  1-cycle pulse at a locked marker slot.
- locked  output  1  alignment acquired.
- errCnt  output  ERR_W  saturating count of marker mismatches while locked.

Behaviour:
- Reset (async, reset=0) forces all outputs to 0 and state to SEARCH. Internal registers clear: phase=0, confirmCnt=0, missCnt=0, expPol=0.
- phase is a 12-bit counter, 0..ORBIT_LEN-1, incrementing every cycle and wrapping to 0. phase==0 defines the expected marker slot.
- expPol is the polarity expected at the next marker: 1 means 0xFFFF, 0 means 0x0000.
- Only 0xFFFF can arm a search, because 0x0000 is the normal no-hit word.
- SEARCH:
  - locked=0, hitsValid=0.
  - On encTrigHits==0xFFFF: next-cycle phase=1, expPol=0, confirmCnt=1, go to CONFIRM.
- CONFIRM:
  - At phase==0, if input equals the expPol pattern: confirmCnt+1 and expPol toggles.
  - If confirmCnt+1 reaches LOCK_THRESH, go to LOCKED and assert locked starting the next cycle.
  - Any mismatch at phase==0 returns to SEARCH; that cycle's input is not re-used for arming.
- LOCKED:
  - At phase==0, expPol toggles regardless of the result (flywheel).
  - Match: missCnt=0.
  - Mismatch: missCnt+1 and errCnt+1, with errCnt saturating at all-ones.
  - When missCnt reaches UNLOCK_THRESH, go to SEARCH; locked deasserts the next cycle.
- Output pipeline: one register stage; outputs reflect the input sampled on the previous edge.
  - Marker slot (phase==0) while LOCKED: trigHits=0x0000, hitsValid=0, markerSeen=1.
  - Any other slot while LOCKED: trigHits=encTrigHits, hitsValid=1, markerSeen=0.
  - Not LOCKED: trigHits=encTrigHits raw, hitsValid=0, markerSeen=0.
- bcid = emptySlotBCID + phase, modulo ORBIT_LEN, computed in 13 bits and then reduced.
  - bcid equals emptySlotBCID when markerSeen=1.
  - bcid is 0 when not locked.
- clrErr:
  - clrErr zeroes errCnt on the next edge.
  - clrErr takes priority over a simultaneous increment.
- Entering SEARCH from any state clears confirmCnt and missCnt. errCnt is retained.
- reset asserted mid-orbit takes effect immediately. After release, the block searches afresh.

Test Plan:
1. ORBIT_LEN=16 with the encoder model emitting 0xFFFF/0x0000 markers, emptySlotBCID=5 and random hits elsewhere (never 0xFFFF) -> locked rises 1 cycle after the 4th marker. Thereafter markerSeen pulses every 16 cycles with bcid=5, trigHits matches input delayed 1 cycle, errCnt=0.
2. Spurious 0xFFFF hit word while in SEARCH, 7 cycles before the true marker -> CONFIRM fails at the next phase==0 check, the block returns to SEARCH, and it locks on the true marker sequence by its 4th marker.
3. Once locked, corrupt one marker by replacing 0x0000 with 0x1234 -> locked stays 1, errCnt=1, markerSeen still pulses, and the next marker with correct polarity clears missCnt.
4. Once locked, shift the marker position by 3 cycles for 3 orbits -> errCnt=3, locked=0 after the 3rd miss, and relock occurs at the new phase after 4 markers.
5. Force errCnt to saturate with ERR_W=2 through repeated misses -> errCnt holds at 3. Assert clrErr on a mismatch cycle -> errCnt=0.
6. Assert reset while locked, mid-orbit -> all outputs go to 0 asynchronously. After release, locked=0 until 4 fresh markers have been received.
